// File: rtl/aemb_pipe_ctrl.sv
// AEMB pipeline sequencer: stage-advance and slot-valid enables, falling-edge domain.
// Optional data-bus timeout is enabled by defining AEMB_DWB_TIMEOUT_EN.
module aemb_pipe_ctrl #(
  parameter int unsigned RST_CYC = 4,
  parameter int unsigned DWB_TMO = 16
) (
  input  logic       nclk,
  input  logic       nrst,
  input  logic       iwb_ack_i,
  input  logic       dwb_ack_i,
  input  logic       rDWBSTB,
  input  logic       rBRA,
  input  logic       rDLY,
  output logic       nrun,
  output logic       frun,
  output logic       drun,
  output logic [1:0] rSTATE,
  output logic       dwb_err_o
);

  typedef enum logic [1:0] {
    StReset  = 2'd0,
    StRun    = 2'd1,
    StIstall = 2'd2,
    StDstall = 2'd3
  } state_e;

`ifdef AEMB_DWB_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  localparam logic [7:0] TmoLast = 8'(DWB_TMO - 1);
  localparam logic [3:0] RstLast = 4'(RST_CYC - 1);

  state_e      r_state, w_state_d;
  logic  [3:0] r_rst_cnt, w_rst_cnt_d;
  logic  [7:0] r_wait_cnt, w_wait_cnt_d;
  logic        r_frun, w_frun_d;
  logic        r_drun, w_drun_d;
  logic        w_dwait;
  logic        w_tmo;
  logic        w_nrun;

  always_comb begin
    w_dwait = rDWBSTB & ~dwb_ack_i;
    // With the timeout disabled this folds to 0 and the pipe waits for dwb_ack_i forever.
    w_tmo   = TmoEn & (r_wait_cnt == TmoLast);
    w_nrun  = (r_state != StReset) & iwb_ack_i & (~rDWBSTB | dwb_ack_i | w_tmo);
  end

  always_comb begin
    w_state_d   = r_state;
    w_rst_cnt_d = r_rst_cnt;
    if (r_state == StReset) begin
      if (r_rst_cnt == 4'd0) begin
        w_state_d = StRun;
      end else begin
        w_rst_cnt_d = r_rst_cnt - 4'd1;
      end
    end else if (w_dwait && !w_tmo) begin
      w_state_d = StDstall;
    end else if (!iwb_ack_i) begin
      w_state_d = StIstall;
    end else begin
      w_state_d = StRun;
    end
  end

  // Wait cycles are only counted once the pipe is live; the reset hold is not a bus wait.
  always_comb begin
    w_wait_cnt_d = r_wait_cnt;
    if (w_nrun) begin
      w_wait_cnt_d = 8'd0;
    end else if (r_state != StReset && w_dwait && r_wait_cnt != 8'hFF) begin
      w_wait_cnt_d = r_wait_cnt + 8'd1;
    end
  end

  always_comb begin
    w_frun_d = r_frun;
    w_drun_d = r_drun;
    if (w_nrun) begin
      if (rBRA && !rDLY) begin
        w_frun_d = 1'b0;
        w_drun_d = 1'b0;
      end else if (rBRA) begin
        w_frun_d = 1'b0;
        w_drun_d = r_frun;
      end else begin
        w_frun_d = 1'b1;
        w_drun_d = r_frun;
      end
    end
  end

  always_ff @(negedge nclk or posedge nrst) begin
    if (nrst) begin
      r_state    <= StReset;
      r_rst_cnt  <= RstLast;
      r_wait_cnt <= 8'd0;
      r_frun     <= 1'b0;
      r_drun     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_rst_cnt  <= w_rst_cnt_d;
      r_wait_cnt <= w_wait_cnt_d;
      r_frun     <= w_frun_d;
      r_drun     <= w_drun_d;
    end
  end

  assign nrun      = w_nrun;
  assign frun      = r_frun;
  assign drun      = r_drun;
  assign rSTATE    = r_state;
  assign dwb_err_o = w_nrun & w_tmo & w_dwait;

endmodule

// File: tb/tb_aemb_pipe_ctrl.sv
// Directed bench for aemb_pipe_ctrl; observes outputs on the rising edge, away from the
// falling active edge. Timeout expectations follow AEMB_DWB_TIMEOUT_EN.
module tb_aemb_pipe_ctrl;

  logic       nclk = 1'b1;
  logic       nrst = 1'b1;
  logic       iwb_ack_i = 1'b1;
  logic       dwb_ack_i = 1'b1;
  logic       rDWBSTB = 1'b0;
  logic       rBRA = 1'b0;
  logic       rDLY = 1'b0;
  logic       nrun, frun, drun, dwb_err_o;
  logic [1:0] rSTATE;

  int n_pass  = 0;
  int n_total = 0;

  // in  = {iwb_ack_i, dwb_ack_i, rDWBSTB, rBRA, rDLY}
  // exp = {nrun, frun, drun, rSTATE[1:0], dwb_err_o}
  typedef struct packed {
    logic [4:0] in;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[25];

  always #5 nclk = ~nclk;

  aemb_pipe_ctrl #(
    .RST_CYC(4),
    .DWB_TMO(16)
  ) dut (
    .nclk     (nclk),
    .nrst     (nrst),
    .iwb_ack_i(iwb_ack_i),
    .dwb_ack_i(dwb_ack_i),
    .rDWBSTB  (rDWBSTB),
    .rBRA     (rBRA),
    .rDLY     (rDLY),
    .nrun     (nrun),
    .frun     (frun),
    .drun     (drun),
    .rSTATE   (rSTATE),
    .dwb_err_o(dwb_err_o)
  );

  task automatic drive(input logic [4:0] in);
    {iwb_ack_i, dwb_ack_i, rDWBSTB, rBRA, rDLY} = in;
  endtask

  task automatic check(input string nm, input logic [5:0] exp);
    logic [5:0] act;
    act = {nrun, frun, drun, rSTATE, dwb_err_o};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: nrun/frun/drun/state/err got %b expected %b", nm, act, exp);
  endtask

  // Apply inputs just after a falling edge, check mid-cycle, move past the next falling edge.
  task automatic cycle(input string nm, input logic [4:0] in, input logic [5:0] exp);
    drive(in);
    @(posedge nclk);
    check(nm, exp);
    @(negedge nclk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{5'b11000, 6'b000000};  // reset hold, 4 cycles
    vecs[1]  = '{5'b11000, 6'b000000};
    vecs[2]  = '{5'b11000, 6'b000000};
    vecs[3]  = '{5'b11000, 6'b000000};
    vecs[4]  = '{5'b11000, 6'b100010};  // first advance
    vecs[5]  = '{5'b11000, 6'b110010};
    vecs[6]  = '{5'b11000, 6'b111010};
    vecs[7]  = '{5'b11010, 6'b111010};  // taken branch, no delay slot
    vecs[8]  = '{5'b11000, 6'b100010};
    vecs[9]  = '{5'b11000, 6'b110010};
    vecs[10] = '{5'b11000, 6'b111010};
    vecs[11] = '{5'b11011, 6'b111010};  // taken branch with delay slot
    vecs[12] = '{5'b11000, 6'b101010};
    vecs[13] = '{5'b11000, 6'b110010};
    vecs[14] = '{5'b10100, 6'b011010};  // data wait, 3 cycles
    vecs[15] = '{5'b10110, 6'b011110};  // branch while stalled is ignored
    vecs[16] = '{5'b10100, 6'b011110};
    vecs[17] = '{5'b11100, 6'b111110};  // data ack
    vecs[18] = '{5'b11000, 6'b111010};
    vecs[19] = '{5'b00100, 6'b011010};  // both buses wait
    vecs[20] = '{5'b00100, 6'b011110};
    vecs[21] = '{5'b01100, 6'b011110};  // data done, instr still waits
    vecs[22] = '{5'b00000, 6'b011100};
    vecs[23] = '{5'b10000, 6'b111100};
    vecs[24] = '{5'b11000, 6'b111010};

    @(negedge nclk);
    #1;
    @(posedge nclk);
    check("reset_state", 6'b000000);
    @(negedge nclk);
    #1;
    nrst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp);
    end

    // Data-bus wait with no ack ever.
`ifdef AEMB_DWB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      cycle($sformatf("tmo_wait%0d", k), 5'b10100,
            {(k == 16), 2'b11, (k == 1) ? 2'd1 : 2'd3, (k == 16)});
    end
    // Counter cleared: a fresh wait starts from zero.
    cycle("tmo_after", 5'b10100, 6'b011010);
    cycle("tmo_restart", 5'b10100, 6'b011110);
`else
    for (int k = 1; k <= 100; k++) begin
      cycle($sformatf("notmo_wait%0d", k), 5'b10100, {3'b011, (k == 1) ? 2'd1 : 2'd3, 1'b0});
    end
    cycle("notmo_ack", 5'b11100, 6'b111110);
    cycle("notmo_stall_again", 5'b10100, 6'b011010);
`endif

    // Reset arriving mid-stall discards everything and reruns the hold.
    #2;
    nrst = 1'b1;
    #1;
    check("midstall_reset", 6'b000000);
    @(negedge nclk);
    #1;
    nrst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle($sformatf("rerun_hold%0d", i), 5'b11000, 6'b000000);
    end
    cycle("rerun_first_adv", 5'b11000, 6'b100010);
    cycle("rerun_second_adv", 5'b11000, 6'b110010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
